// File: rtl/slc3_pkg.sv
// Shared types for the SLC-3 control sequencer: state enum, opcodes,
// mux encodings and the packed control word driven onto the datapath.
package slc3_pkg;

    typedef enum logic [4:0] {
        HALTED, S18, S33, S35, S32,
        S00, S01, S04, S05, S06, S07, S09, S12,
        S16, S21, S22, S23, S25, S27,
        PAUSE1, PAUSE2
    } state_t;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_PSE = 4'b1101;

    localparam logic [1:0] PCMUX_PC1   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic [1:0] ADDR2_ZERO   = 2'b00;
    localparam logic [1:0] ADDR2_SEXT6  = 2'b01;
    localparam logic [1:0] ADDR2_SEXT9  = 2'b10;
    localparam logic [1:0] ADDR2_SEXT11 = 2'b11;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    localparam logic [1:0] DRMUX_IR = 2'b00;
    localparam logic [1:0] DRMUX_R7 = 2'b01;

    typedef struct packed {
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_cc;
        logic       ld_reg;
        logic       ld_pc;
        logic       ld_led;
        logic [1:0] pcmux;
        logic [1:0] drmux;
        logic       sr1mux;
        logic       sr2mux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mio_en;
        logic       mem_oe;
        logic       mem_we;
    } ctrl_t;

    // Idle control word: nothing driven, nothing loaded, SRAM strobes released.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c        = '0;
        c.mem_oe = 1'b1;
        c.mem_we = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/slc3_control_fsm_mem_wait_counter.sv
// Fixed-length memory wait timer shared by all SRAM access states.
// Held at zero while start is high; done flags the last wait cycle.
module mem_wait_counter #(
    parameter int MEM_WAIT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic done
);

    localparam int            W    = $clog2(MEM_WAIT + 1);
    localparam logic [W-1:0]  LAST = W'(MEM_WAIT - 1);

    logic [W-1:0] count_r;

    // Count up to LAST and saturate there until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (start) begin
            count_r <= '0;
        end else if (count_r != LAST) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == LAST);

endmodule

// File: rtl/slc3_control_fsm.sv
// SLC-3 fetch/decode/execute sequencer. Control word is decoded from the
// next state and registered, so it lines up with the state register.
// Optional pause instruction (opcode 1101) is built when SLC3_PAUSE_EN is defined.
module slc3_control_fsm
    import slc3_pkg::*;
#(
    parameter int MEM_WAIT = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic [1:0] PCMUX,
    output logic [1:0] DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       MIO_EN,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    state_t state_r, state_s;
    ctrl_t  ctrl_r, ctrl_s;
    logic   in_wait_s;
    logic   wait_done_s;

`ifndef SLC3_PAUSE_EN
    logic unused_continue_s;
    assign unused_continue_s = Continue;
`endif

    assign in_wait_s = (state_r == S33) || (state_r == S25) || (state_r == S16);

    mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .clk   (Clk),
        .rst_n (Reset),
        .start (!in_wait_s),
        .done  (wait_done_s)
    );

    // State and registered control word.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= HALTED;
            ctrl_r  <= ctrl_idle();
        end else begin
            state_r <= state_s;
            ctrl_r  <= ctrl_s;
        end
    end

    // Next-state sequencing.
    always_comb begin
        state_s = state_r;
        case (state_r)
            HALTED: state_s = Run ? S18 : HALTED;
            S18:    state_s = S33;
            S33:    state_s = wait_done_s ? S35 : S33;
            S35:    state_s = S32;
            S32: begin
                case (Opcode)
                    OP_ADD:  state_s = S01;
                    OP_AND:  state_s = S05;
                    OP_NOT:  state_s = S09;
                    OP_BR:   state_s = S00;
                    OP_JMP:  state_s = S12;
                    OP_JSR:  state_s = IR_11 ? S04 : S18;
                    OP_LDR:  state_s = S06;
                    OP_STR:  state_s = S07;
`ifdef SLC3_PAUSE_EN
                    OP_PSE:  state_s = PAUSE1;
`endif
                    default: state_s = S18;
                endcase
            end
            S00:    state_s = BEN ? S22 : S18;
            S04:    state_s = S21;
            S06:    state_s = S25;
            S25:    state_s = wait_done_s ? S27 : S25;
            S07:    state_s = S23;
            S23:    state_s = S16;
            S16:    state_s = wait_done_s ? S18 : S16;
            S01, S05, S09, S12, S21, S22, S27: state_s = S18;
`ifdef SLC3_PAUSE_EN
            PAUSE1: state_s = Continue ? PAUSE2 : PAUSE1;
            PAUSE2: state_s = Continue ? PAUSE2 : S18;
`endif
            default: state_s = HALTED;
        endcase
    end

    // Control word for the state being entered.
    always_comb begin
        ctrl_s = ctrl_idle();
        case (state_s)
            S18: begin
                ctrl_s.gate_pc = 1'b1;
                ctrl_s.ld_mar  = 1'b1;
                ctrl_s.pcmux   = PCMUX_PC1;
                ctrl_s.ld_pc   = 1'b1;
            end
            S33, S25: begin
                ctrl_s.mem_oe = 1'b0;
                ctrl_s.mio_en = 1'b1;
                ctrl_s.ld_mdr = 1'b1;
            end
            S35: begin
                ctrl_s.gate_mdr = 1'b1;
                ctrl_s.ld_ir    = 1'b1;
            end
            S32: ctrl_s.ld_ben = 1'b1;
            S01, S05: begin
                ctrl_s.sr1mux   = 1'b1;
                ctrl_s.sr2mux   = IR_5;
                ctrl_s.aluk     = (state_s == S05) ? ALUK_AND : ALUK_ADD;
                ctrl_s.gate_alu = 1'b1;
                ctrl_s.ld_reg   = 1'b1;
                ctrl_s.ld_cc    = 1'b1;
                ctrl_s.drmux    = DRMUX_IR;
            end
            S09: begin
                ctrl_s.sr1mux   = 1'b1;
                ctrl_s.aluk     = ALUK_NOT;
                ctrl_s.gate_alu = 1'b1;
                ctrl_s.ld_reg   = 1'b1;
                ctrl_s.ld_cc    = 1'b1;
            end
            S22, S21: begin
                ctrl_s.addr1mux = 1'b0;
                ctrl_s.addr2mux = (state_s == S21) ? ADDR2_SEXT11 : ADDR2_SEXT9;
                ctrl_s.pcmux    = PCMUX_ADDER;
                ctrl_s.ld_pc    = 1'b1;
            end
            S12: begin
                ctrl_s.sr1mux   = 1'b1;
                ctrl_s.aluk     = ALUK_PASSA;
                ctrl_s.gate_alu = 1'b1;
                ctrl_s.pcmux    = PCMUX_BUS;
                ctrl_s.ld_pc    = 1'b1;
            end
            S04: begin
                ctrl_s.gate_pc = 1'b1;
                ctrl_s.drmux   = DRMUX_R7;
                ctrl_s.ld_reg  = 1'b1;
            end
            S06, S07: begin
                ctrl_s.addr1mux    = 1'b1;
                ctrl_s.sr1mux      = 1'b1;
                ctrl_s.addr2mux    = ADDR2_SEXT6;
                ctrl_s.gate_marmux = 1'b1;
                ctrl_s.ld_mar      = 1'b1;
            end
            S27: begin
                ctrl_s.gate_mdr = 1'b1;
                ctrl_s.ld_reg   = 1'b1;
                ctrl_s.ld_cc    = 1'b1;
                ctrl_s.drmux    = DRMUX_IR;
            end
            S23: begin
                // Store data comes from the source register through the ALU.
                ctrl_s.sr1mux   = 1'b0;
                ctrl_s.aluk     = ALUK_PASSA;
                ctrl_s.gate_alu = 1'b1;
                ctrl_s.mio_en   = 1'b0;
                ctrl_s.ld_mdr   = 1'b1;
            end
            S16:    ctrl_s.mem_we = 1'b0;
            PAUSE1: ctrl_s.ld_led = 1'b1;
            default: ctrl_s = ctrl_idle();
        endcase
    end

    assign GatePC     = ctrl_r.gate_pc;
    assign GateMDR    = ctrl_r.gate_mdr;
    assign GateALU    = ctrl_r.gate_alu;
    assign GateMARMUX = ctrl_r.gate_marmux;
    assign LD_MAR     = ctrl_r.ld_mar;
    assign LD_MDR     = ctrl_r.ld_mdr;
    assign LD_IR      = ctrl_r.ld_ir;
    assign LD_BEN     = ctrl_r.ld_ben;
    assign LD_CC      = ctrl_r.ld_cc;
    assign LD_REG     = ctrl_r.ld_reg;
    assign LD_PC      = ctrl_r.ld_pc;
    assign LD_LED     = ctrl_r.ld_led;
    assign PCMUX      = ctrl_r.pcmux;
    assign DRMUX      = ctrl_r.drmux;
    assign SR1MUX     = ctrl_r.sr1mux;
    assign SR2MUX     = ctrl_r.sr2mux;
    assign ADDR1MUX   = ctrl_r.addr1mux;
    assign ADDR2MUX   = ctrl_r.addr2mux;
    assign ALUK       = ctrl_r.aluk;
    assign MIO_EN     = ctrl_r.mio_en;
    assign Mem_OE     = ctrl_r.mem_oe;
    assign Mem_WE     = ctrl_r.mem_we;

endmodule

// File: tb/tb_slc3_control_fsm.sv
// Self-checking bench for slc3_control_fsm: per-instruction step lists from
// the instruction rules, a latency table, reset/pause sequences, random programs.
module tb_slc3_control_fsm;

    localparam int MW = 3;

    logic       Clk = 1'b0;
    logic       Reset, Run, Continue, IR_5, IR_11, BEN;
    logic [3:0] Opcode;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic [1:0] PCMUX, DRMUX, ADDR2MUX, ALUK;
    logic       SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE, Mem_WE;

    always #5 Clk = ~Clk;

    slc3_control_fsm #(.MEM_WAIT(MW)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
        .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
        .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .MIO_EN(MIO_EN),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    typedef struct packed {
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic [1:0] pcmux, drmux;
        logic       sr1mux, sr2mux, addr1mux;
        logic [1:0] addr2mux, aluk;
        logic       mio_en, mem_oe, mem_we;
    } ctl_t;

    typedef enum {ST_IDLE, ST_FETCH, ST_MEMRD, ST_LDIR, ST_DEC, ST_ADD, ST_AND, ST_NOT,
                  ST_BR, ST_BRT, ST_JMP, ST_JSR, ST_JSRT, ST_ADR, ST_WB, ST_STMDR,
                  ST_MEMWR, ST_LED} step_t;

    typedef struct {
        step_t s;
        logic  ir5;
    } exp_t;

    typedef struct {
        logic [3:0] op;
        logic       ir5, ir11, ben;
        int         cycles;
    } vec_t;

    ctl_t obs;
    assign obs = {GatePC, GateMDR, GateALU, GateMARMUX, LD_MAR, LD_MDR, LD_IR, LD_BEN,
                  LD_CC, LD_REG, LD_PC, LD_LED, PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX,
                  ADDR2MUX, ALUK, MIO_EN, Mem_OE, Mem_WE};

    int   checks = 0;
    int   passes = 0;
    exp_t exp_q[$];
    vec_t tbl[$];

    // Control word each datapath step must present, written from the instruction rules.
    function automatic ctl_t ctl_of(step_t s, logic ir5);
        ctl_t c;
        c = '0;
        c.mem_oe = 1'b1;
        c.mem_we = 1'b1;
        case (s)
            ST_FETCH: begin c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1; end
            ST_MEMRD: begin c.mem_oe = 1'b0; c.mio_en = 1'b1; c.ld_mdr = 1'b1; end
            ST_LDIR:  begin c.gate_mdr = 1'b1; c.ld_ir = 1'b1; end
            ST_DEC:   c.ld_ben = 1'b1;
            ST_ADD, ST_AND: begin
                c.sr1mux = 1'b1; c.sr2mux = ir5; c.gate_alu = 1'b1;
                c.ld_reg = 1'b1; c.ld_cc = 1'b1;
                c.aluk = (s == ST_AND) ? 2'b01 : 2'b00;
            end
            ST_NOT: begin
                c.sr1mux = 1'b1; c.aluk = 2'b10; c.gate_alu = 1'b1;
                c.ld_reg = 1'b1; c.ld_cc = 1'b1;
            end
            ST_BRT:  begin c.addr2mux = 2'b10; c.pcmux = 2'b10; c.ld_pc = 1'b1; end
            ST_JMP: begin
                c.sr1mux = 1'b1; c.aluk = 2'b11; c.gate_alu = 1'b1;
                c.pcmux = 2'b01; c.ld_pc = 1'b1;
            end
            ST_JSR:  begin c.gate_pc = 1'b1; c.drmux = 2'b01; c.ld_reg = 1'b1; end
            ST_JSRT: begin c.addr2mux = 2'b11; c.pcmux = 2'b10; c.ld_pc = 1'b1; end
            ST_ADR: begin
                c.addr1mux = 1'b1; c.sr1mux = 1'b1; c.addr2mux = 2'b01;
                c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
            end
            ST_WB:    begin c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; end
            ST_STMDR: begin c.aluk = 2'b11; c.gate_alu = 1'b1; c.ld_mdr = 1'b1; end
            ST_MEMWR: c.mem_we = 1'b0;
            ST_LED:   c.ld_led = 1'b1;
            default:  ;
        endcase
        return c;
    endfunction

    function automatic void push(step_t s, logic ir5, int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{s, ir5});
    endfunction

    // Reference sequence for one instruction, from FETCH up to (not incl.) the next FETCH.
    function automatic void push_instr(logic [3:0] op, logic ir5, logic ir11, logic ben);
        push(ST_FETCH, 1'b0, 1);
        push(ST_MEMRD, 1'b0, MW);
        push(ST_LDIR, 1'b0, 1);
        push(ST_DEC, 1'b0, 1);
        case (op)
            4'd1:  push(ST_ADD, ir5, 1);
            4'd5:  push(ST_AND, ir5, 1);
            4'd9:  push(ST_NOT, 1'b0, 1);
            4'd0:  begin push(ST_BR, 1'b0, 1); if (ben) push(ST_BRT, 1'b0, 1); end
            4'd12: push(ST_JMP, 1'b0, 1);
            4'd4:  if (ir11) begin push(ST_JSR, 1'b0, 1); push(ST_JSRT, 1'b0, 1); end
            4'd6:  begin push(ST_ADR, 1'b0, 1); push(ST_MEMRD, 1'b0, MW); push(ST_WB, 1'b0, 1); end
            4'd7:  begin push(ST_ADR, 1'b0, 1); push(ST_STMDR, 1'b0, 1); push(ST_MEMWR, 1'b0, MW); end
            default: ;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    endtask

    task automatic cycle();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        Run = 1'b0;
        Continue = 1'b0;
        @(negedge Clk);
        check("reset_idle", obs, ctl_of(ST_IDLE, 1'b0));
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    // Pulse Run; returns at the sample point of the first FETCH cycle.
    task automatic start();
        Run = 1'b1;
        @(posedge Clk);
        #1 Run = 1'b0;
        @(negedge Clk);
    endtask

    // Compare DUT cycle by cycle against the queued steps; returns cycles until next FETCH.
    task automatic trace(input bit rand_run, output int lat);
        exp_t e;
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0 && obs === ctl_of(ST_FETCH, 1'b0) && exp_q.size() == 0) begin
                lat = k;
                break;
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("ctl_step%0d", k), obs, ctl_of(e.s, e.ir5));
            end
            check("strobe_excl", {31'b0, !(obs.mem_oe == 1'b0 && obs.mem_we == 1'b0)}, 32'd1);
            if (rand_run) Run = 1'($urandom_range(0, 1));
            cycle();
        end
        exp_q.delete();
    endtask

    initial begin
        int lat;
        Reset = 1'b0; Run = 1'b0; Continue = 1'b0;
        Opcode = 4'd0; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;

        // Reset then idle with Run low.
        repeat (2) @(negedge Clk);
        check("reset_hold", obs, ctl_of(ST_IDLE, 1'b0));
        Reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("halted_idle", obs, ctl_of(ST_IDLE, 1'b0));
        end

        // Latency table: {opcode, IR_5, IR_11, BEN, cycles FETCH-to-FETCH}.
        tbl.push_back('{4'b0001, 1'b1, 1'b0, 1'b0, 7});
        tbl.push_back('{4'b0001, 1'b0, 1'b0, 1'b0, 7});
        tbl.push_back('{4'b0101, 1'b1, 1'b0, 1'b0, 7});
        tbl.push_back('{4'b1001, 1'b0, 1'b0, 1'b0, 7});
        tbl.push_back('{4'b0000, 1'b0, 1'b0, 1'b0, 7});
        tbl.push_back('{4'b0000, 1'b0, 1'b0, 1'b1, 8});
        tbl.push_back('{4'b1100, 1'b0, 1'b0, 1'b0, 7});
        tbl.push_back('{4'b0100, 1'b0, 1'b1, 1'b0, 8});
        tbl.push_back('{4'b0100, 1'b0, 1'b0, 1'b0, 6});
        tbl.push_back('{4'b0110, 1'b0, 1'b0, 1'b0, 11});
        tbl.push_back('{4'b0111, 1'b0, 1'b0, 1'b0, 11});
        tbl.push_back('{4'b1000, 1'b0, 1'b0, 1'b0, 6});
        tbl.push_back('{4'b1111, 1'b0, 1'b0, 1'b0, 6});
`ifndef SLC3_PAUSE_EN
        tbl.push_back('{4'b1101, 1'b0, 1'b0, 1'b0, 6});
`endif
        foreach (tbl[i]) begin
            do_reset();
            Opcode = tbl[i].op; IR_5 = tbl[i].ir5; IR_11 = tbl[i].ir11; BEN = tbl[i].ben;
            start();
            push_instr(tbl[i].op, tbl[i].ir5, tbl[i].ir11, tbl[i].ben);
            trace(1'b0, lat);
            check($sformatf("latency_op%b", tbl[i].op), lat, tbl[i].cycles);
        end

        // Asynchronous reset in the middle of a store write.
        do_reset();
        Opcode = 4'b0111;
        start();
        repeat (8) cycle();
        check("str_in_write", {31'b0, Mem_WE}, 32'd0);
        #1 Reset = 1'b0;
        #1 check("async_we_release", {31'b0, Mem_WE}, 32'd1);
        check("async_idle", obs, ctl_of(ST_IDLE, 1'b0));
        @(negedge Clk);
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("post_reset_halted", obs, ctl_of(ST_IDLE, 1'b0));
        end
        start();
        check("restart_fetch", obs, ctl_of(ST_FETCH, 1'b0));

`ifdef SLC3_PAUSE_EN
        // Pause holds LD_LED until Continue goes 0 -> 1 -> 0.
        do_reset();
        Opcode = 4'b1101;
        start();
        repeat (6) cycle();
        for (int i = 0; i < 3; i++) begin
            check("pause1_led", obs, ctl_of(ST_LED, 1'b0));
            cycle();
        end
        Continue = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("pause2_idle", obs, ctl_of(ST_IDLE, 1'b0));
        end
        Continue = 1'b0;
        cycle();
        check("pause_resume", obs, ctl_of(ST_FETCH, 1'b0));
`endif

        // Random instruction stream with Run toggling (must be ignored).
        do_reset();
        start();
        for (int n = 0; n < 40; n++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
`ifdef SLC3_PAUSE_EN
            if (op == 4'b1101) op = 4'b0001;
`endif
            Opcode = op;
            IR_5 = 1'($urandom_range(0, 1));
            IR_11 = 1'($urandom_range(0, 1));
            BEN = 1'($urandom_range(0, 1));
            push_instr(op, IR_5, IR_11, BEN);
            trace(1'b1, lat);
            if (lat == 0) check("rand_timeout", 32'd0, 32'd1);
        end
        Run = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/slc3_control_fsm.md
Name: slc3_control_fsm

Overview:
- Instruction sequencer for the SLC-3 datapath: fetch, decode and execute FSM that drives every gate, load-enable, mux-select and memory-strobe input of the datapath.
- Sits between the top level (Run and Continue buttons, SRAM strobes) and the datapath (IR opcode and BEN feedback).
- Memory access uses a fixed, parameterised wait count rather than a ready handshake.

Parameters:
- MEM_WAIT, 3, number of cycles spent in each memory-wait state (minimum 1).

Ports:
- Clk  in  1  system clock; all state changes on the rising edge
- Reset  in  1  asynchronous, active-low; forces state HALTED and the wait counter to 0
- Run  in  1  start request, sampled only in HALTED
- Continue  in  1  resume from pause (PAUSE_EN builds only)
- Opcode  in  4  IR[15:12]
- IR_5  in  1  immediate select for ADD/AND
- IR_11  in  1  JSR/JSRR select
- BEN  in  1  branch-enable flag from the datapath
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register loads
- PCMUX  out  2  00 = PC+1, 01 = bus, 10 = address adder
- DRMUX  out  2  00 = IR[11:9], 01 = R7
- SR1MUX  out  1  0 = IR[11:9], 1 = IR[8:6]
- SR2MUX  out  1  0 = register, 1 = SEXT5 immediate
- ADDR1MUX  out  1  0 = PC, 1 = SR1
- ADDR2MUX  out  2  00 = 0, 01 = SEXT6, 10 = SEXT9, 11 = SEXT11
- ALUK  out  2  00 = ADD, 01 = AND, 10 = NOT, 11 = PASS A
- MIO_EN  out  1  MDR loads from memory (1) or from the bus (0)
- Mem_OE, Mem_WE  out  1 each  SRAM strobes, active-low

Behaviour:
- Moore outputs. Every output defaults to 0 (Mem_OE and Mem_WE default to 1) in every state unless listed below.
- Reset and HALTED hold the default outputs.
- State transitions:
  - HALTED: Run=1 goes to S18, otherwise hold.
  - S18: GatePC, LD_MAR, PCMUX=00, LD_PC; go to S33.
  - S33: Mem_OE=0, MIO_EN=1, LD_MDR; hold for MEM_WAIT cycles, then go to S35.
  - S35: GateMDR, LD_IR; go to S32.
  - S32: LD_BEN; dispatch on Opcode.
- Dispatch targets from S32:
  - 0001 goes to S01 (ADD): SR1MUX=1, SR2MUX=IR_5, ALUK=00, GateALU, LD_REG, LD_CC, DRMUX=00.
  - 0101 goes to S05 (AND): as S01 with ALUK=01.
  - 1001 goes to S09 (NOT): SR1MUX=1, ALUK=10, GateALU, LD_REG, LD_CC.
  - 0000 goes to S00 (BR): BEN=1 goes to S22, else S18. S22: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC.
  - 1100 goes to S12 (JMP): SR1MUX=1, ALUK=11, GateALU, PCMUX=01, LD_PC.
  - 0100 with IR_11=1 goes to S04 (JSR): GatePC, DRMUX=01, LD_REG. S04 goes to S21: ADDR1MUX=0, ADDR2MUX=11, PCMUX=10, LD_PC.
  - 0110 goes to S06 (LDR): ADDR1MUX=1, SR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR. Then S25 (as S33, MEM_WAIT cycles), then S27: GateMDR, LD_REG, LD_CC, DRMUX=00.
  - 0111 goes to S07 (STR): address as S06. Then S23: SR1MUX=0, ALUK=11, GateALU, MIO_EN=0, LD_MDR. Then S16: Mem_WE=0 for MEM_WAIT cycles.
- All execute states return to S18 when complete.
- Illegal opcodes, including JSRR (0100 with IR_11=0), go from S32 to S18 with no side effects.
- Wait counter: width $clog2(MEM_WAIT+1). Cleared on entry to each wait state. The exit condition is count == MEM_WAIT-1.
- Latency with MEM_WAIT=3:
  - fetch + decode: 6 cycles
  - ADD/AND/NOT/JMP: 7 total
  - taken BR and JSR: 8 total
  - LDR: 11 total
  - STR: 11 total
- Run is ignored outside HALTED. Reset asserted mid-instruction returns to HALTED within the same cycle (asynchronous); no strobe stays low.

Optional Feature:
- SLC3_PAUSE_EN defined:
  - Opcode 1101 dispatches to PAUSE1: LD_LED=1; hold while Continue=0; Continue=1 goes to PAUSE2.
  - PAUSE2: hold while Continue=1; Continue=0 goes to S18.
- SLC3_PAUSE_EN undefined: 1101 is illegal (S32 to S18), and Continue is unused.

Decomposition:
- Package slc3_pkg holds:
  - the state enum
  - opcode localparams
  - PCMUX, ADDR2MUX, ALUK and DRMUX encodings
- One sub-module is natural: mem_wait_counter (start, done, MEM_WAIT parameter), shared by S33, S25 and S16.

Test Plan:
- Reset low, then high with Run=0 for 10 cycles: state HALTED, all loads 0, Mem_OE=Mem_WE=1.
- Run pulse, Opcode=0001, IR_5=1: S18 asserts GatePC, LD_MAR, LD_PC; Mem_OE=0 for exactly 3 cycles; LD_IR on cycle 5; LD_BEN on cycle 6; cycle 7 has SR2MUX=1, ALUK=00, LD_REG, LD_CC; cycle 8 is S18.
- Opcode=0000 with BEN=0, then BEN=1: not taken returns to S18 after S00; taken shows PCMUX=10, ADDR2MUX=10, LD_PC in S22.
- Opcode=0111 (STR): S23 has MIO_EN=0, LD_MDR, ALUK=11; Mem_WE=0 for 3 cycles; never simultaneous with Mem_OE=0.
- Opcode=0100 with IR_11=1, then IR_11=0: JSR gives DRMUX=01, LD_REG, then ADDR2MUX=11, LD_PC; JSRR is treated as illegal, S32 to S18 with no loads.
- Reset asserted during S16 of STR: Mem_WE returns to 1 asynchronously; HALTED until the next Run. With SLC3_PAUSE_EN, 1101 holds LD_LED until Continue toggles 0 to 1 to 0.
